// File: rtl/ysyx_25070198_ifu_pf.sv
// ysyx_25070198_ifu_pf: prefetching instruction fetch unit.
//
// Keeps a DEPTH-entry FIFO of {pc, instruction} pairs ahead of decode.
// It issues one instruction memory request at a time over a valid/ready
// request channel and waits for a single valid response. A redirect flushes
// the FIFO and restarts fetch at the new pc. If the redirect arrives after a
// request was accepted, the response to that request is stale and is
// discarded in the DROP state.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   redirect(_pc)      flush and restart fetch at redirect_pc & ~3
//   req_valid/addr     fetch request to instruction memory
//   req_ready          memory accepts the request
//   resp_valid/data    one response per accepted request
//   resp_err           access fault for the response
//   inst_valid/inst    FIFO head presented to decode
//   inst_pc            pc of the head entry
//   inst_ready         decode consumes the head
//   inst_fault         head entry carries an access fault
//   fifo_count         number of occupied FIFO entries
//
// Optional feature macro: IFU_ACCESS_FAULT_EN
//   Defined:   resp_err is stored per entry and shown on inst_fault. Fetch
//              halts after a faulted entry is pushed and resumes only on
//              redirect.
//   Undefined: resp_err is ignored and inst_fault is tied to 0.
module ysyx_25070198_ifu_pf #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   req_valid,
    output logic [ADDR_W-1:0]      req_addr,
    input  logic                   req_ready,
    input  logic                   resp_valid,
    input  logic [DATA_W-1:0]      resp_data,
    input  logic                   resp_err,
    output logic                   inst_valid,
    output logic [DATA_W-1:0]      inst,
    output logic [ADDR_W-1:0]      inst_pc,
    input  logic                   inst_ready,
    output logic                   inst_fault,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] fifo_inst_q [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
    logic              empty, push, pop, halted;
    logic              unused_pc_lsb;

`ifdef IFU_ACCESS_FAULT_EN
    logic fifo_fault_q [DEPTH];
    logic halt_q, halt_d;
    assign halted = halt_q;
`else
    logic unused_resp_err;
    assign unused_resp_err = resp_err;
    assign halted          = 1'b0;
`endif

    assign unused_pc_lsb = ^redirect_pc[1:0];

    // Fetch FSM and fetch pc
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
`ifdef IFU_ACCESS_FAULT_EN
        halt_d     = halt_q;
`endif
        case (state_q)
            // Outstanding-slot reservation: a request is only started from
            // IDLE, where nothing is in flight, so count alone bounds it.
            S_IDLE: if (!halted && (count_q < DEPTH_C)) state_d = S_REQ;
            S_REQ: begin
                if (req_ready) begin
                    state_d    = S_WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                end
            end
            S_WAIT: begin
                if (resp_valid) begin
                    state_d = S_IDLE;
                    push    = 1'b1;
`ifdef IFU_ACCESS_FAULT_EN
                    halt_d  = halt_q | resp_err;
`endif
                end
            end
            S_DROP: if (resp_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything; an accepted-but-unanswered request
        // leaves a stale response behind, which DROP swallows.
        if (redirect) begin
            push       = 1'b0;
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
`ifdef IFU_ACCESS_FAULT_EN
            halt_d     = 1'b0;
`endif
            case (state_q)
                S_REQ:          state_d = req_ready  ? S_DROP : S_IDLE;
                S_WAIT, S_DROP: state_d = resp_valid ? S_IDLE : S_DROP;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    // FIFO pointers
    assign empty      = (count_q == '0);
    assign inst_valid = !empty && !redirect;
    assign pop        = inst_valid && inst_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
`ifdef IFU_ACCESS_FAULT_EN
            halt_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
`ifdef IFU_ACCESS_FAULT_EN
            halt_q     <= halt_d;
`endif
        end
    end

    // Storage needs no reset: outputs are gated by empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= resp_data;
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
`ifdef IFU_ACCESS_FAULT_EN
            fifo_fault_q[wr_ptr_q] <= resp_err;
`endif
        end
    end

    assign req_valid  = (state_q == S_REQ);
    assign req_addr   = fetch_pc_q;
    assign inst       = empty ? '0 : fifo_inst_q[rd_ptr_q];
    assign inst_pc    = empty ? '0 : fifo_pc_q[rd_ptr_q];
    assign fifo_count = count_q;
`ifdef IFU_ACCESS_FAULT_EN
    assign inst_fault = !empty && fifo_fault_q[rd_ptr_q];
`else
    assign inst_fault = 1'b0;
`endif

endmodule

// File: doc/ysyx_25070198_ifu_pf.md
Name: ysyx_25070198_ifu_pf

Overview:
- Parametrised prefetching instruction fetch unit; next generation of the single-state-machine IFU.
- Keeps a DEPTH-entry instruction FIFO (pc + instruction pairs) ahead of decode.
- Talks to instruction memory over a valid/ready request and valid response handshake, with one request outstanding.
- Supports redirect (jump/branch) flush, including discard of a stale in-flight response.
- Sits between the instruction memory port and IDU/EXU; decode consumes through a valid/ready interface.

Parameters:
- ADDR_W, 32, address and pc width.
- DATA_W, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- RESET_PC, 32'h80000000, pc after reset (ADDR_W bits).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] are ignored and treated as 0.
- req_valid  out  1  fetch request valid.
- req_addr  out  ADDR_W  fetch address; word aligned.
- req_ready  in  1  memory accepts the request.
- resp_valid  in  1  response data valid; one response per accepted request.
- resp_data  in  DATA_W  fetched word.
- resp_err  in  1  access fault for this response (used only with the optional feature).
- inst_valid  out  1  FIFO head valid to decode.
- inst  out  DATA_W  head instruction.
- inst_pc  out  ADDR_W  pc of the head instruction.
- inst_ready  in  1  decode consumes the head.
- inst_fault  out  1  head entry carries an access fault (optional feature).
- fifo_count  out  $clog2(DEPTH)+1  occupied entries, for debug and performance.

Behaviour:
- Reset (asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; state=IDLE.
  - req_valid=0, req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_fault=0, fifo_count=0.
- States:
  - IDLE: no request.
  - REQ: req_valid=1, req_addr=fetch_pc.
  - WAIT: request accepted, awaiting resp_valid.
  - DROP: awaiting a stale response to discard.
- Transitions (redirect=0):
  - IDLE->REQ when fifo_count + (state==WAIT) < DEPTH. A slot is reserved for every outstanding response, so the FIFO never overflows.
  - REQ->WAIT on req_ready; captures req_pc=fetch_pc and sets fetch_pc += 4 (wraps modulo 2^ADDR_W).
  - REQ holds req_valid and req_addr stable until req_ready.
  - WAIT->IDLE on resp_valid; pushes {req_pc, resp_data, resp_err} to the FIFO.
  - DROP->IDLE on resp_valid; data is discarded and nothing is pushed.
- Minimum latency:
  - Reset release to first req_valid: 1 cycle.
  - resp_valid to inst_valid: 1 cycle (registered FIFO).
  - Zero-wait memory sustains one instruction every 3 cycles (IDLE, REQ, WAIT).
- Redirect (highest priority):
  - FIFO cleared and fetch_pc=redirect_pc&~3 next cycle.
  - inst_valid is forced 0 combinationally in the redirect cycle; pop is ignored.
  - From IDLE: stays IDLE.
  - From REQ without req_ready: request withdrawn, go IDLE. This is the only case a request may drop unaccepted.
  - From REQ with req_ready: go DROP.
  - From WAIT without resp_valid: go DROP.
  - From WAIT with resp_valid: the response is discarded; go IDLE.
  - From DROP without resp_valid: stays DROP.
  - From DROP with resp_valid: go IDLE. Only one response is outstanding, so that response is the stale one.
- Decode side:
  - inst_valid = !empty && !redirect.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle are both performed; fifo_count is unchanged.
  - The FIFO pointers wrap at DEPTH.
- A resp_valid received in IDLE or REQ is a protocol violation and is ignored.
- An asynchronous rst mid-transaction returns the block to the reset state. The memory side must also be reset.

Optional Feature:
- Macro: IFU_ACCESS_FAULT_EN.
- Defined:
  - resp_err is stored per entry and presented on inst_fault with the head.
  - Once a faulted entry is pushed, fetch halts in IDLE until the next redirect, so a trap handler can restart fetch.
- Undefined:
  - resp_err is ignored, inst_fault is tied to 0, and the entry fault bit is not implemented.

Test Plan:
- Reset, zero-wait memory, inst_ready=1 -> req_addr 0x80000000, 0x80000004, 0x80000008 in order; inst_pc follows the same sequence; each instruction appears 1 cycle after its resp_valid.
- inst_ready=0, zero-wait memory, DEPTH=4 -> fifo_count reaches 4; no req_valid while full plus outstanding; raising inst_ready drains 0x80000000..0x8000000C in order.
- Redirect to 0x80001002 while in WAIT, response arrives 2 cycles later -> response discarded; FIFO empty; next req_addr=0x80001000.
- Redirect in REQ with req_ready=0 -> req_valid drops next cycle; next request uses the new pc; no DROP state.
- Redirect and resp_valid in the same WAIT cycle -> no push; next state IDLE; next req_addr=redirect_pc.
- With IFU_ACCESS_FAULT_EN, resp_err=1 at 0x80000008 -> that entry has inst_fault=1; no further req_valid until redirect to 0x80000100, which resumes fetch there.
